// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU-control codes, FSM state encodings and the control-vector layout
// for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BNEAL = 6'b010110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StREx     = 4'd7,
    StRWb     = 4'd8,
    StOriEx   = 4'd9,
    StOriWb   = 4'd10,
    StBeqEx   = 4'd11,
    StBnealEx = 4'd12,
    StJump    = 4'd13
  } ctrl_state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcwritecond_ne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       link;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       ori_id;
    logic       bneal_id;
  } ctrl_vec_t;

  localparam int unsigned CtrlW = $bits(ctrl_vec_t);

  function automatic logic is_known_op(logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_BNEAL};
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure state -> control-vector lookup for the MIPS main controller.
// With MIPSCTL_MEMWAIT_EN defined, FETCH's PC/IR loads are qualified by mem_ready.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]       state_i,
  input  logic             mem_ready_i,
  output logic [CtrlW-1:0] ctrl_o
);

  ctrl_vec_t c;
  logic      fetch_go;

`ifdef MIPSCTL_MEMWAIT_EN
  assign fetch_go = mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign fetch_go         = 1'b1;
`endif

  always_comb begin
    c = '0;
    unique case (ctrl_state_e'(state_i))
      StFetch: begin
        c.memread = 1'b1;
        c.irwrite = fetch_go;
        c.pcwrite = fetch_go;
        c.alusrcb = SRCB_FOUR;
      end
      StDecode: c.alusrcb = SRCB_BRANCH;
      StMemAdr: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      StMemRd: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWb: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StMemWr: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      StREx: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluop   = ALUOP_FUNCT;
      end
      StRWb: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      StOriEx: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
        c.ori_id  = 1'b1;
      end
      StOriWb: c.regwrite = 1'b1;
      StBeqEx: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      // Link writes PC (already PC+4) on the same edge the branch may reload it.
      StBnealEx: begin
        c.alusrca        = 1'b1;
        c.aluop          = ALUOP_ADD;
        c.bneal_id       = 1'b1;
        c.pcwritecond_ne = 1'b1;
        c.pcsource       = PCSRC_ALUOUT;
        c.regwrite       = 1'b1;
        c.link           = 1'b1;
      end
      StJump: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main-control FSM: state register, opcode dispatch and output unpacking.
// Optional MIPSCTL_MEMWAIT_EN makes FETCH/MEMRD/MEMWR wait for mem_ready.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW    = 6,
  parameter int unsigned STATEW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic              pcwritecond_ne,
  output logic              iord,
  output logic              memread,
  output logic              memwrite,
  output logic              irwrite,
  output logic              memtoreg,
  output logic              link,
  output logic              regdst,
  output logic              regwrite,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsource,
  output logic              aluop1,
  output logic              aluop0,
  output logic              ori_identifier,
  output logic              bneal_identifier,
  output logic              illegal_op,
  output logic [STATEW-1:0] state_dbg
);

  ctrl_state_e      state_q, state_d;
  logic             op_sw_q, op_sw_d;
  logic             mem_go;
  logic [CtrlW-1:0] ctrl_bits;
  ctrl_vec_t        ctrl;

  // The branch decision is made in the datapath from pcwritecond/_ne and zero.
  logic unused_zero;
  assign unused_zero = zero;

`ifdef MIPSCTL_MEMWAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    op_sw_d = op_sw_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_go) state_d = StDecode;
      StDecode: begin
        // Opcode is only sampled here; remember lw vs sw for MEMADR.
        op_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StREx;
          OP_BEQ:       state_d = StBeqEx;
          OP_J:         state_d = StJump;
          OP_ORI:       state_d = StOriEx;
          OP_BNEAL:     state_d = StBnealEx;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = op_sw_q ? StMemWr : StMemRd;
      StMemRd:   if (mem_go) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_go) state_d = StFetch;
      StREx:     state_d = StRWb;
      StRWb:     state_d = StFetch;
      StOriEx:   state_d = StOriWb;
      StOriWb:   state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StBnealEx: state_d = StFetch;
      StJump:    state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_sw_q <= op_sw_d;
    end
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_bits)
  );

  assign ctrl             = ctrl_vec_t'(ctrl_bits);
  assign pcwrite          = ctrl.pcwrite;
  assign pcwritecond      = ctrl.pcwritecond;
  assign pcwritecond_ne   = ctrl.pcwritecond_ne;
  assign iord             = ctrl.iord;
  assign memread          = ctrl.memread;
  assign memwrite         = ctrl.memwrite;
  assign irwrite          = ctrl.irwrite;
  assign memtoreg         = ctrl.memtoreg;
  assign link             = ctrl.link;
  assign regdst           = ctrl.regdst;
  assign regwrite         = ctrl.regwrite;
  assign alusrca          = ctrl.alusrca;
  assign alusrcb          = ctrl.alusrcb;
  assign pcsource         = ctrl.pcsource;
  assign aluop1           = ctrl.aluop[1];
  assign aluop0           = ctrl.aluop[0];
  assign ori_identifier   = ctrl.ori_id;
  assign bneal_identifier = ctrl.bneal_id;
  assign illegal_op       = (state_q == StDecode) && !is_known_op(opcode);
  assign state_dbg        = STATEW'(state_q);

endmodule
